// File: rtl/debounce_scheduler.sv
// Shared-timer debounce engine: a round-robin scanner hands one pending
// channel at a time to a single down-counting timer, which first validates
// the edge and then holds the engine in lockout after committing it.
module debounce_scheduler #(
  parameter int Channel_Count          = 4,
  parameter int Validation_Wait_Cycles = 500_000,
  parameter int Lockout_Cycles         = 5_000_000
) (
  input  logic                             clk,
  input  logic                             async_rst,
  input  logic                             clk_en,
  input  logic [Channel_Count-1:0]         io_in,
  output logic [Channel_Count-1:0]         state_out,
  output logic                             change_valid,
  output logic [$clog2(Channel_Count)-1:0] change_index,
  output logic                             change_level,
  output logic                             busy
);

  localparam int IndexWidth = $clog2(Channel_Count);
  localparam int MaxCycles  = (Validation_Wait_Cycles > Lockout_Cycles) ?
                              Validation_Wait_Cycles : Lockout_Cycles;
  localparam int TimerWidth = $clog2(MaxCycles + 1);

  localparam logic [TimerWidth-1:0] ValidateLoad = TimerWidth'(Validation_Wait_Cycles - 1);
  localparam logic [TimerWidth-1:0] LockoutLoad  = TimerWidth'(Lockout_Cycles - 1);
  localparam logic [TimerWidth-1:0] TimerOne     = TimerWidth'(1);
  localparam logic [IndexWidth-1:0] LastIndex    = IndexWidth'(Channel_Count - 1);
  localparam logic [IndexWidth-1:0] IndexOne     = IndexWidth'(1);

  typedef enum logic [1:0] {
    SCAN,
    VALIDATE,
    LOCKOUT
  } state_t;

  state_t                   state_q, state_d;
  logic [Channel_Count-1:0] sync_meta, sync;
  logic [IndexWidth-1:0]    ptr_q, ptr_d;
  logic [IndexWidth-1:0]    active_q, active_d;
  logic [TimerWidth-1:0]    timer_q, timer_d;
  logic [Channel_Count-1:0] state_out_d;
  logic                     commit;

  // Round-robin successor; Channel_Count need not be a power of two.
  function automatic logic [IndexWidth-1:0] next_index(input logic [IndexWidth-1:0] idx);
    return (idx == LastIndex) ? '0 : idx + IndexOne;
  endfunction

  // Two-flop synchronizer on every pad; it only advances on enabled cycles.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else if (clk_en) begin
      sync_meta <= io_in;
      sync      <= sync_meta;
    end
  end

  // Next-state logic: scan for a mismatch, validate it, then lock out.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    active_d    = active_q;
    timer_d     = timer_q;
    state_out_d = state_out;
    commit      = 1'b0;
    if (clk_en) begin
      case (state_q)
        SCAN: begin
          if (sync[ptr_q] != state_out[ptr_q]) begin
            active_d = ptr_q;
            timer_d  = ValidateLoad;
            state_d  = VALIDATE;
          end else begin
            ptr_d = next_index(ptr_q);
          end
        end
        VALIDATE: begin
          if (sync[active_q] == state_out[active_q]) begin
            ptr_d   = next_index(active_q);
            state_d = SCAN;
          end else if (timer_q == '0) begin
            state_out_d[active_q] = ~state_out[active_q];
            commit                = 1'b1;
            timer_d               = LockoutLoad;
            state_d               = LOCKOUT;
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            ptr_d   = next_index(active_q);
            state_d = SCAN;
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State register plus the registered one-cycle change event.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q      <= SCAN;
      ptr_q        <= '0;
      active_q     <= '0;
      timer_q      <= '0;
      state_out    <= '0;
      change_valid <= 1'b0;
      change_index <= '0;
      change_level <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      active_q     <= active_d;
      timer_q      <= timer_d;
      state_out    <= state_out_d;
      change_valid <= commit;
      if (commit) begin
        change_index <= active_q;
        change_level <= state_out_d[active_q];
      end
    end
  end

  assign busy = (state_q != SCAN);

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler: a behavioural model tracks the
// expected debounced levels and events, directed scenarios pin the model to
// hand-derived numbers, and a randomized phase stresses the arbitration.
module tb_debounce_scheduler;

  localparam int N = 4;
  localparam int V = 4;
  localparam int L = 6;

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       clk_en = 1'b1;
  logic [3:0] io_in = 4'b0000;
  logic [3:0] state_out;
  logic       change_valid;
  logic [1:0] change_index;
  logic       change_level;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  debounce_scheduler #(
    .Channel_Count(N),
    .Validation_Wait_Cycles(V),
    .Lockout_Cycles(L)
  ) dut (
    .clk(clk),
    .async_rst(async_rst),
    .clk_en(clk_en),
    .io_in(io_in),
    .state_out(state_out),
    .change_valid(change_valid),
    .change_index(change_index),
    .change_level(change_level),
    .busy(busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Behavioural model: mode 0 = looking for work, 1 = edge being timed,
  // 2 = post-commit hold. Elapsed counts up toward V or L.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
  int         m_mode = 0, m_ch = 0, m_ptr = 0, m_elapsed = 0, m_idx = 0;
  logic       m_cv = 1'b0, m_lvl = 1'b0;

  always @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      m_mode = 0; m_ch = 0; m_ptr = 0; m_elapsed = 0; m_idx = 0;
      m_cv = 1'b0; m_lvl = 1'b0;
    end else begin
      m_cv = 1'b0;
      if (clk_en) begin
        if (m_mode == 0) begin
          if (m_s2[m_ptr] != m_deb[m_ptr]) begin
            m_mode = 1; m_ch = m_ptr; m_elapsed = 0;
          end else begin
            m_ptr = (m_ptr + 1) % N;
          end
        end else if (m_mode == 1) begin
          if (m_s2[m_ch] == m_deb[m_ch]) begin
            m_mode = 0; m_ptr = (m_ch + 1) % N;
          end else begin
            m_elapsed++;
            if (m_elapsed == V) begin
              m_deb[m_ch] = ~m_deb[m_ch];
              m_cv = 1'b1; m_idx = m_ch; m_lvl = m_deb[m_ch];
              m_mode = 2; m_elapsed = 0;
            end
          end
        end else begin
          m_elapsed++;
          if (m_elapsed == L) begin
            m_mode = 0; m_ptr = (m_ch + 1) % N;
          end
        end
        m_s2 = m_s1;
        m_s1 = io_in;
      end
    end
  end

  // Observation bookkeeping.
  int         cyc_count = 0, pulse_count = 0, model_pulses = 0, busy_cycles = 0;
  int         run_len = 0, max_run = 0;
  int         ev_idx[$], ev_cyc[$];
  logic       en_at_edge = 1'b1, rst_seen = 1'b0;
  logic [3:0] prev_state = '0;
  logic       prev_busy = 1'b0;

  always @(posedge clk) begin
    cyc_count++;
    en_at_edge <= clk_en;
  end

  always @(posedge async_rst) rst_seen = 1'b1;

  // Per-cycle comparison against the model plus hold-when-disabled check.
  always @(negedge clk) begin
    check_output("model_outputs", {state_out, change_valid, busy},
                 {m_deb, m_cv, (m_mode != 0)});
    if (m_cv) check_output("model_event", {change_index, change_level}, {m_idx[1:0], m_lvl});
    if (!rst_seen && !async_rst && !en_at_edge)
      check_output("hold_when_disabled", {state_out, busy, change_valid},
                   {prev_state, prev_busy, 1'b0});
    prev_state = state_out;
    prev_busy  = busy;
    rst_seen   = 1'b0;
    if (m_cv) model_pulses++;
    if (busy) busy_cycles++;
    if (change_valid) begin
      pulse_count++;
      ev_idx.push_back(int'(change_index));
      ev_cyc.push_back(cyc_count);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic apply_stimulus(input logic [3:0] io, input logic en, input int cycles);
    io_in  = io;
    clk_en = en;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    async_rst = 1'b1;
    @(posedge clk);
    #2;
    async_rst = 1'b0;
  endtask

  // Waits (bounded) until state_out[ch] is 1; returns negedges waited.
  task automatic wait_level(input int ch, input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (state_out[ch] !== 1'b1 && waited < limit);
    @(posedge clk);
    #2;
  endtask

  int base, base_busy, waited, i0, i1, gap;

  initial begin
    // Reset asserted asynchronously before any clock edge.
    #1 async_rst = 1'b1;
    #1;
    check_output("reset_outputs", {state_out, change_valid, change_index, change_level, busy}, 0);
    @(posedge clk);
    #2;
    async_rst = 1'b0;

    // Scenario 1: quiet inputs.
    apply_stimulus(4'b0000, 1'b1, 20);
    check_output("s1_state", state_out, 0);
    check_output("s1_no_pulse", pulse_count, 0);
    check_output("s1_never_busy", busy_cycles, 0);

    // Scenario 2: single rising edge on channel 2.
    base      = pulse_count;
    base_busy = busy_cycles;
    io_in     = 4'b0100;
    wait_level(2, 30, waited);
    check_output("s2_latency_bound", (waited >= 1 && waited <= 2 + 3 + V + 1), 1);
    check_output("s2_state", state_out, 4'b0100);
    apply_stimulus(4'b0100, 1'b1, 8);
    check_output("s2_one_pulse", pulse_count - base, 1);
    check_output("s2_event", {ev_idx[ev_idx.size()-1], 1'b1}, {32'd2, change_level});
    check_output("s2_busy_len", busy_cycles - base_busy, V + L);
    check_output("s2_idle_after", busy, 0);

    // Scenario 3: two-cycle glitch on channel 1.
    base = pulse_count;
    apply_stimulus(4'b0110, 1'b1, 2);
    apply_stimulus(4'b0100, 1'b1, 20);
    check_output("s3_state", state_out, 4'b0100);
    check_output("s3_no_pulse", pulse_count - base, 0);

    // Scenario 4: channels 0 and 3 together, arriving when ptr is 0.
    io_in = 4'b0000;
    do_reset();
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    ev_idx.delete();
    ev_cyc.delete();
    base  = pulse_count;
    io_in = 4'b1001;
    waited = 0;
    while (pulse_count - base < 2 && waited < 60) begin
      @(negedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #2;
    i0  = (ev_idx.size() > 0) ? ev_idx[0] : -1;
    i1  = (ev_idx.size() > 1) ? ev_idx[1] : -1;
    gap = (ev_cyc.size() > 1) ? ev_cyc[1] - ev_cyc[0] : -1;
    check_output("s4_two_pulses", pulse_count - base, 2);
    check_output("s4_first_ch", i0, 0);
    check_output("s4_second_ch", i1, 3);
    check_output("s4_gap_min", (gap >= L + V), 1);
    check_output("s4_gap_exact", gap, 13);
    check_output("s4_state", state_out, 4'b1001);

    // Scenario 5: channel 2 edge with clk_en toggling.
    io_in = 4'b0000;
    do_reset();
    apply_stimulus(4'b0000, 1'b1, 6);
    base    = pulse_count;
    max_run = 0;
    io_in   = 4'b0100;
    waited  = 0;
    for (int k = 1; k <= 40; k++) begin
      clk_en = (k % 2 == 1);
      @(negedge clk);
      #1;
      if (state_out[2] === 1'b1 && waited == 0) waited = k;
      @(posedge clk);
      #2;
    end
    clk_en = 1'b1;
    check_output("s5_latency_bound", (waited >= 1 && waited <= 2 * (2 + 3 + V + 1)), 1);
    check_output("s5_one_pulse", pulse_count - base, 1);
    check_output("s5_pulse_width", max_run, 1);

    // Scenario 6: async reset mid-validation, then full re-debounce.
    io_in = 4'b0000;
    do_reset();
    apply_stimulus(4'b0000, 1'b1, 6);
    io_in  = 4'b0100;
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (busy !== 1'b1 && waited < 12);
    @(posedge clk);
    #3;
    check_output("s6_busy_before_reset", busy, 1);
    async_rst = 1'b1;
    #1;
    check_output("s6_reset_clears", {state_out, busy, change_valid}, 0);
    @(posedge clk);
    #2;
    async_rst = 1'b0;
    base = pulse_count;
    wait_level(2, 30, waited);
    apply_stimulus(4'b0100, 1'b1, 4);
    check_output("s6_state", state_out, 4'b0100);
    check_output("s6_one_pulse", pulse_count - base, 1);

    // Randomized phase: sparse input flips, random enable, rare resets.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        io_in[b] = ~io_in[b];
      end
      clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        async_rst = 1'b1;
        #2;
        async_rst = 1'b0;
      end
      @(posedge clk);
      #2;
    end
    apply_stimulus(io_in, 1'b1, 20);
    check_output("event_total", pulse_count, model_pulses);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
